mux_nne1_rr: RTL and testbench

Parametrised, registered successor to the CPU's 4-to-1 combinational selector. It picks one of `N` `W`-bit source channels, either by an explicit select code or by round-robin arbitration among valid sources, and presents the winner through a single output register with a valid/ready handshake. It sits between multiple producers (ALU result, load data, immediate path, forwarding paths) and a single consumer stage in the 24-bit datapath.

---
 rtl/mux_nne1_rr.sv | 120 ++++++++++++
 tb/tb_mux_nne1_rr.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nne1_rr.sv
// rtl/mux_nne1_rr.sv - registered N-to-1 channel selector with fixed or round-robin grant
//
// Picks one of N W-bit source channels, either by the explicit select code S
// (Mode=0) or by round-robin arbitration among valid sources (Mode=1), and
// presents the winner through a single output register with valid/ready.
//
// Ports:
//   Clock        in   rising-edge clock
//   Reset        in   asynchronous, active-high; clears the output register and Prio
//   Hyrja        in   N*W flattened channel data, channel k at [k*W +: W]
//   HyrjaValid   in   N   per-channel valid
//   HyrjaReady   out  N   per-channel ready, combinational, at most one bit high
//   S            in   SW  channel select used in fixed mode
//   Mode         in   0 = fixed select by S, 1 = round-robin
//   Dalja        out  W   registered output data
//   DaljaValid   out  output register holds data
//   DaljaReady   in   consumer accepts Dalja this cycle
//   DaljaKanali  out  SW  index of the channel that produced Dalja

module mux_nne1_rr #(
   parameter int W  = 24,
   parameter int N  = 4,
   parameter int SW = 2
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic [N*W-1:0]  Hyrja,
   input  logic [N-1:0]    HyrjaValid,
   output logic [N-1:0]    HyrjaReady,
   input  logic [SW-1:0]   S,
   input  logic            Mode,
   output logic [W-1:0]    Dalja,
   output logic            DaljaValid,
   input  logic            DaljaReady,
   output logic [SW-1:0]   DaljaKanali
);

   logic          le;
   logic [SW-1:0] prio;
   logic          grant_ok;
   logic [SW-1:0] grant;
   logic          hi_ok;
   logic [SW-1:0] hi_g;
   logic          lo_ok;
   logic [SW-1:0] lo_g;
   logic [W-1:0]  sel_data;

   // The register can take a new word when it is empty or being drained.
   assign le = !DaljaValid || DaljaReady;

   // Grant selection. The select code is compared against every channel index
   // rather than used as an index, so an out-of-range S simply matches nothing.
   // Round-robin is split into two scans: channels at or above Prio first
   // (hi), then those below it (lo); the descending loops leave the lowest
   // matching index in each half.
   always_comb begin
      grant_ok = 1'b0;
      grant    = '0;
      hi_ok    = 1'b0;
      hi_g     = '0;
      lo_ok    = 1'b0;
      lo_g     = '0;
      if (!Mode) begin
         for (int k = 0; k < N; k++) begin
            if (S == SW'(k) && HyrjaValid[k]) begin
               grant_ok = 1'b1;
               grant    = SW'(k);
            end
         end
      end else begin
         for (int k = N - 1; k >= 0; k--) begin
            if (HyrjaValid[k]) begin
               if (k >= int'(prio)) begin
                  hi_ok = 1'b1;
                  hi_g  = SW'(k);
               end else begin
                  lo_ok = 1'b1;
                  lo_g  = SW'(k);
               end
            end
         end
         grant_ok = hi_ok || lo_ok;
         grant    = hi_ok ? hi_g : lo_g;
      end
   end

   // Data mux and ready decode; only in-range channel indices are ever read.
   always_comb begin
      sel_data   = '0;
      HyrjaReady = '0;
      for (int k = 0; k < N; k++) begin
         if (grant == SW'(k)) begin
            sel_data      = Hyrja[k*W +: W];
            HyrjaReady[k] = grant_ok && le;
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         Dalja       <= '0;
         DaljaValid  <= 1'b0;
         DaljaKanali <= '0;
         prio        <= '0;
      end else if (le) begin
         if (grant_ok) begin
            Dalja       <= sel_data;
            DaljaKanali <= grant;
            DaljaValid  <= 1'b1;
            // Only round-robin transfers move the pointer past the winner.
            if (Mode) begin
               prio <= (grant == SW'(N - 1)) ? '0 : grant + SW'(1);
            end
         end else begin
            DaljaValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_nne1_rr.sv
// tb/tb_mux_nne1_rr.sv - scoreboard bench for mux_nne1_rr
module tb_mux_nne1_rr;
   localparam int W  = 24;
   localparam int N  = 4;
   localparam int SW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic [N*W-1:0] hyrja;
   logic [N-1:0]   hvalid;
   logic [N-1:0]   hready;
   logic [SW-1:0]  s;
   logic           mode;
   logic [W-1:0]   dalja;
   logic           dvalid;
   logic           dready;
   logic [SW-1:0]  dk;

   logic [3*W-1:0] hyrja3;
   logic [2:0]     hvalid3;
   logic [2:0]     hready3;
   logic [SW-1:0]  s3;
   logic           mode3;
   logic [W-1:0]   dalja3;
   logic           dvalid3;
   logic           dready3;
   logic [SW-1:0]  dk3;

   mux_nne1_rr #(.W(W), .N(N), .SW(SW)) dut (
      .Clock(clk), .Reset(rst), .Hyrja(hyrja), .HyrjaValid(hvalid),
      .HyrjaReady(hready), .S(s), .Mode(mode), .Dalja(dalja),
      .DaljaValid(dvalid), .DaljaReady(dready), .DaljaKanali(dk)
   );

   mux_nne1_rr #(.W(W), .N(3), .SW(SW)) dut3 (
      .Clock(clk), .Reset(rst), .Hyrja(hyrja3), .HyrjaValid(hvalid3),
      .HyrjaReady(hready3), .S(s3), .Mode(mode3), .Dalja(dalja3),
      .DaljaValid(dvalid3), .DaljaReady(dready3), .DaljaKanali(dk3)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [SW-1:0] k;
      logic [W-1:0]  d;
   } word_t;

   word_t sb[$];
   int    mprio;
   logic  mv;

   function automatic int mgrant(input logic [N-1:0] v, input logic m,
                                 input logic [SW-1:0] sel, input int p);
      if (!m) begin
         if (int'(sel) < N && v[sel]) return int'(sel);
         return -1;
      end
      for (int i = 0; i < N; i++) begin
         if (v[(p + i) % N]) return (p + i) % N;
      end
      return -1;
   endfunction

   task automatic randomize_data();
      for (int k = 0; k < N; k++) hyrja[k*W +: W] = W'($urandom);
   endtask

   task automatic step();
      int         g;
      logic       le;
      logic [3:0] exp_rdy;
      word_t      w;
      #1;
      g  = mgrant(hvalid, mode, s, mprio);
      le = !mv || dready;
      exp_rdy = '0;
      if (g >= 0 && le) exp_rdy[g] = 1'b1;
      check("hready", 32'(hready), 32'(exp_rdy));
      check("dvalid", 32'(dvalid), 32'(mv));
      if (dvalid && dready) begin
         check("sb_depth", sb.size(), 1);
         if (sb.size() > 0) begin
            w = sb.pop_front();
            check("sb_kanali", 32'(dk), 32'(w.k));
            check("sb_data", 32'(dalja), 32'(w.d));
         end
      end
      if (g >= 0 && le) begin
         w.k = SW'(g);
         w.d = hyrja[g*W +: W];
         sb.push_back(w);
      end
      @(posedge clk);
      if (le) begin
         mv = (g >= 0);
         if (g >= 0 && mode) mprio = (g == N - 1) ? 0 : g + 1;
      end
      @(negedge clk);
   endtask

   initial begin
      int         rot[6];
      int         sp[4];
      logic [W-1:0]  held;
      logic [SW-1:0] heldk;
      rot = '{0, 1, 2, 3, 0, 1};
      sp  = '{3, 1, 3, 1};

      rst = 1'b1; hyrja = '0; hvalid = '0; s = '0; mode = 1'b0; dready = 1'b0;
      hyrja3 = '0; hvalid3 = '0; s3 = '0; mode3 = 1'b0; dready3 = 1'b0;
      mv = 1'b0; mprio = 0;
      repeat (2) @(negedge clk);
      check("reset_dvalid", 32'(dvalid), 0);
      check("reset_dalja", 32'(dalja), 0);
      check("reset_dk", 32'(dk), 0);
      rst = 1'b0;

      // fixed select
      randomize_data();
      hyrja[2*W +: W] = 24'hABCDEF;
      hvalid = 4'hf; mode = 1'b0; s = 2'd2; dready = 1'b1;
      #1 check("fixed_hready", 32'(hready), 32'h4);
      step();
      check("fixed_dalja", 32'(dalja), 32'hABCDEF);
      check("fixed_dk", 32'(dk), 2);
      check("fixed_dvalid", 32'(dvalid), 1);

      // round-robin rotation, no bubbles
      mode = 1'b1;
      for (int i = 0; i < 6; i++) begin
         randomize_data();
         step();
         check("rot_dk", 32'(dk), 32'(rot[i]));
         check("rot_dvalid", 32'(dvalid), 1);
      end

      // sparse: channels 1 and 3 alternate
      hvalid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         randomize_data();
         step();
         check("sparse_dk", 32'(dk), 32'(sp[i]));
      end
      hvalid = 4'b0100; randomize_data(); step();
      check("prio3_setup_dk", 32'(dk), 2);
      hvalid = 4'b0001; randomize_data(); step();
      check("wrap_dk", 32'(dk), 0);
      hvalid = 4'hf; randomize_data(); step();
      check("prio_after_wrap_dk", 32'(dk), 1);

      // backpressure
      dready = 1'b0;
      held = dalja; heldk = dk;
      for (int i = 0; i < 3; i++) begin
         randomize_data();
         #1 check("bp_hready", 32'(hready), 0);
         step();
         check("bp_dalja", 32'(dalja), 32'(held));
         check("bp_dk", 32'(dk), 32'(heldk));
      end
      dready = 1'b1; randomize_data(); step();
      check("bp_release_dk", 32'(dk), 2);
      check("bp_release_dvalid", 32'(dvalid), 1);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         randomize_data();
         hvalid = N'($urandom);
         mode   = 1'($urandom);
         s      = SW'($urandom);
         dready = ($urandom_range(0, 9) < 7);
         step();
      end

      // asynchronous reset mid-stall
      mode = 1'b1; hvalid = 4'hf; dready = 1'b1; randomize_data();
      step();
      dready = 1'b0;
      #3 rst = 1'b1;
      #1;
      check("arst_dvalid", 32'(dvalid), 0);
      check("arst_dalja", 32'(dalja), 0);
      check("arst_dk", 32'(dk), 0);
      sb.delete(); mv = 1'b0; mprio = 0;
      @(negedge clk);
      rst = 1'b0; dready = 1'b1; randomize_data();
      #1 check("arst_rr_hready", 32'(hready), 32'h1);
      step();
      check("arst_rr_dk", 32'(dk), 0);

      // out-of-range select on the three-channel instance
      for (int k = 0; k < 3; k++) hyrja3[k*W +: W] = W'($urandom);
      hvalid3 = 3'b111; mode3 = 1'b0; s3 = 2'd0; dready3 = 1'b1;
      @(posedge clk); @(negedge clk);
      check("oor_load_dvalid", 32'(dvalid3), 1);
      check("oor_load_dk", 32'(dk3), 0);
      check("oor_load_dalja", 32'(dalja3), 32'(hyrja3[0 +: W]));
      s3 = 2'd3; dready3 = 1'b0;
      #1 check("oor_stall_hready", 32'(hready3), 0);
      @(posedge clk); @(negedge clk);
      check("oor_stall_dvalid", 32'(dvalid3), 1);
      dready3 = 1'b1;
      #1 check("oor_hready", 32'(hready3), 0);
      @(posedge clk); @(negedge clk);
      check("oor_drain_dvalid", 32'(dvalid3), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
